comparison_sequencer: RTL

Clocked controller for the combinational 4-bit comparison datapath (equal / greater / less-than / max, selected by a 2-bit operation code). On a start request it latches one operand pair, steps the operation code through all four operations, and captures each 8-bit result. It then presents the packed results and rotates them onto the display path at a fixed dwell rate. It sits between the board switch/button inputs and the comparison datapath, and its display outputs feed the 7-segment decode.

---
 rtl/comparison_pkg.sv | 27 ++
 rtl/comparison_if.sv | 25 ++
 rtl/comparison_sequencer_dwell_timer.sv | 29 ++
 rtl/comparison_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/comparison_pkg.sv
// Shared constants, state encoding and result-format helper
// for the comparison sequencer.
package comparison_pkg;

    localparam logic [1:0] OP_EQ  = 2'd0;
    localparam logic [1:0] OP_GT  = 2'd1;
    localparam logic [1:0] OP_LT  = 2'd2;
    localparam logic [1:0] OP_MAX = 2'd3;

    localparam int RESULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Booleans may only use bit 0; max may only use the low nibble.
    function automatic logic formatOk(
        input logic [1:0]          op,
        input logic [RESULT_W-1:0] r
    );
        if (op == OP_MAX) return (r[7:4] == 4'd0);
        return (r[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/comparison_if.sv
// Bus between the sequencer and the combinational
// comparison datapath.
interface comparison_if;
    import comparison_pkg::*;

    logic [3:0]          cmp_x;
    logic [3:0]          cmp_y;
    logic [1:0]          op_sel;
    logic [RESULT_W-1:0] cmp_result;

    modport master (
        output cmp_x,
        output cmp_y,
        output op_sel,
        input  cmp_result
    );

    modport slave (
        input  cmp_x,
        input  cmp_y,
        input  op_sel,
        output cmp_result
    );

endinterface

// File: rtl/comparison_sequencer_dwell_timer.sv
// DWELL-cycle counter: one-cycle tick every DWELL
// un-cleared cycles, restarting from zero on clear.
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/comparison_sequencer.sv
// Steps the comparison datapath through all four ops,
// captures the results and rotates them onto the display.
module comparison_sequencer
    import comparison_pkg::*;
#(
    parameter int DWELL = 50_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          x_in,
    input  logic [3:0]          y_in,
    comparison_if.master        dp,
    output logic                busy,
    output logic                done,
    output logic                eq,
    output logic                gt,
    output logic                lt,
    output logic [3:0]          max_val,
    output logic                err,
    output logic [1:0]          disp_op,
    output logic [RESULT_W-1:0] disp_value
);

    state_t state;
    state_t nextState;

    logic [1:0]          k;
    logic [3:0]          xReg;
    logic [3:0]          yReg;
    logic [RESULT_W-1:0] res [4];
    logic [1:0]          dispOp;
    logic                accept;
    logic                capture;
    logic                tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                capture = 1'b1;
                if (k == OP_MAX) nextState = SHOW;
            end
            SHOW: begin
                if (start) begin
                    accept    = 1'b1;
                    nextState = RUN;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xReg    <= '0;
            yReg    <= '0;
            k       <= '0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            max_val <= '0;
            err     <= 1'b0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else begin
            done <= capture && (k == OP_MAX);
            if (accept) begin
                xReg <= x_in;
                yReg <= y_in;
                k    <= '0;
                err  <= 1'b0;
            end
            if (capture) begin
                res[k] <= dp.cmp_result;
                k      <= k + 2'd1;
                if (!formatOk(k, dp.cmp_result)) err <= 1'b1;
                unique case (k)
                    OP_EQ:  eq      <= dp.cmp_result[0];
                    OP_GT:  gt      <= dp.cmp_result[0];
                    OP_LT:  lt      <= dp.cmp_result[0];
                    OP_MAX: max_val <= dp.cmp_result[3:0];
                    default: ;
                endcase
            end
        end
    end

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != SHOW),
        .tick   (tick)
    );

    // Rotation only survives while staying in SHOW; any entry restarts at op 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dispOp <= '0;
        end else if (state == SHOW && nextState == SHOW) begin
            if (tick) dispOp <= dispOp + 2'd1;
        end else begin
            dispOp <= '0;
        end
    end

    always_comb begin
        dp.op_sel = 2'd0;
        unique case (state)
            RUN:     dp.op_sel = k;
            SHOW:    dp.op_sel = dispOp;
            default: dp.op_sel = 2'd0;
        endcase
    end

    assign dp.cmp_x    = xReg;
    assign dp.cmp_y    = yReg;
    assign busy        = (state == RUN);
    assign disp_op     = dispOp;
    assign disp_value  = (state == SHOW) ? res[dispOp] : '0;

endmodule
